// File: rtl/mchan_fifo_lvl.sv
// Single-clock req/gnt FIFO with arbitrary depth, optional fall-through bypass,
// fill level, almost-full/almost-empty flags and synchronous flush.
module mchan_fifo_lvl #(
    parameter int DATA_WIDTH   = 32,
    parameter int DATA_DEPTH   = 8,
    parameter int FALL_THROUGH = 0,
    parameter int AF_THRESH    = DATA_DEPTH - 1,
    parameter int AE_THRESH    = 1
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              flush_i,
    input  logic [DATA_WIDTH-1:0]             push_dat_i,
    input  logic                              push_req_i,
    output logic                              push_gnt_o,
    output logic [DATA_WIDTH-1:0]             pop_dat_o,
    output logic                              pop_gnt_o,
    input  logic                              pop_req_i,
    output logic [$clog2(DATA_DEPTH+1)-1:0]   level_o,
    output logic                              almost_full_o,
    output logic                              almost_empty_o
);

    localparam int ADDR_W = (DATA_DEPTH > 2) ? $clog2(DATA_DEPTH) : 1;
    localparam int LVL_W  = $clog2(DATA_DEPTH + 1);

    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DATA_DEPTH - 1);
    localparam logic [LVL_W-1:0]  FULL_LVL = LVL_W'(DATA_DEPTH);
    localparam logic [LVL_W-1:0]  AF_LVL   = LVL_W'(AF_THRESH);
    localparam logic [LVL_W-1:0]  AE_LVL   = LVL_W'(AE_THRESH);
    localparam bit                FT       = (FALL_THROUGH != 0);

    // Elaboration-time sanity check on parameter ranges.
    if (DATA_WIDTH < 1 || DATA_DEPTH < 2 ||
        AF_THRESH < 1 || AF_THRESH > DATA_DEPTH ||
        AE_THRESH < 0 || AE_THRESH > DATA_DEPTH - 1) begin : g_param_err
        $error("mchan_fifo_lvl: illegal parameter combination");
    end

    logic [DATA_WIDTH-1:0] storage [DATA_DEPTH];
    logic [ADDR_W-1:0]     rd_ptr;
    logic [ADDR_W-1:0]     wr_ptr;
    logic [LVL_W-1:0]      level;

    logic full;
    logic empty;
    logic push_fire;
    logic pop_fire;
    logic ft_pass;
    logic do_write;
    logic do_read;

    function automatic logic [ADDR_W-1:0] next_ptr(input logic [ADDR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + ADDR_W'(1);
    endfunction

    assign full  = (level == FULL_LVL);
    assign empty = (level == '0);

    assign push_gnt_o = !full && !flush_i;
    assign pop_gnt_o  = (!empty || (FT && push_req_i)) && !flush_i;
    assign pop_dat_o  = (FT && empty) ? push_dat_i : storage[rd_ptr];

    assign push_fire = push_req_i && push_gnt_o;
    assign pop_fire  = pop_req_i && pop_gnt_o;

    // An empty fall-through FIFO hands the push word straight to the popper,
    // leaving storage, pointers and level untouched.
    assign ft_pass  = FT && empty && push_fire && pop_fire;
    assign do_write = push_fire && !ft_pass;
    assign do_read  = pop_fire && !ft_pass;

    always_ff @(posedge clk_i) begin
        if (do_write) begin
            storage[wr_ptr] <= push_dat_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
        end else if (flush_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_write) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (do_read) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            if (do_write && !do_read) begin
                level <= level + LVL_W'(1);
            end else if (do_read && !do_write) begin
                level <= level - LVL_W'(1);
            end
        end
    end

    assign level_o        = level;
    assign almost_full_o  = (level >= AF_LVL);
    assign almost_empty_o = (level <= AE_LVL);

endmodule
